// File: rtl/network_sequencer.sv
// rtl/network_sequencer.sv - host-side job sequencer in front of the network controller
module network_sequencer #(
  parameter int INPUT_SIZE       = 2,
  parameter int OUTPUT_SIZE      = 1,
  parameter int BITSTREAM_LENGTH = 256,
  parameter int TIMEOUT_CYCLES   = 300
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INPUT_SIZE-1:0][31:0] in_data,
  output logic [7:0]                  net_ctrl,
  input  logic [7:0]                  net_stat,
  output logic [INPUT_SIZE-1:0][31:0] net_data,
  input  logic [OUTPUT_SIZE-1:0][31:0] net_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUTPUT_SIZE-1:0][31:0] out_data,
  output logic                        busy,
  output logic                        timeout_err,
  output logic [15:0]                 job_count
);

  // The timeout is never allowed to be shorter than one full bitstream pass
  // plus the start/capture overhead, otherwise every job would time out.
  localparam int TIMEOUT_LIM = (TIMEOUT_CYCLES > BITSTREAM_LENGTH + 2) ?
                               TIMEOUT_CYCLES : BITSTREAM_LENGTH + 3;
  localparam int CNT_W       = $clog2(TIMEOUT_LIM + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               wait_cnt_q, wait_cnt_d;
  logic [INPUT_SIZE-1:0][31:0]    net_data_q, net_data_d;
  logic [OUTPUT_SIZE-1:0][31:0]   out_data_q, out_data_d;
  logic [15:0]                    job_count_q, job_count_d;
  logic                           timeout_err_q, timeout_err_d;

  // Only the finish flag matters here; controller state bits are informational.
  logic unused_stat;
  assign unused_stat = ^net_stat[7:1];

  // State and datapath registers; reset returns everything to idle immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      wait_cnt_q    <= '0;
      net_data_q    <= '0;
      out_data_q    <= '0;
      job_count_q   <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      net_data_q    <= net_data_d;
      out_data_q    <= out_data_d;
      job_count_q   <= job_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next-state logic: accept, pulse start, wait for finish or timeout, hand off result.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    net_data_d    = net_data_q;
    out_data_d    = out_data_q;
    job_count_d   = job_count_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          net_data_d = in_data;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        wait_cnt_d = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // Finish takes priority over a coinciding timeout.
        if (net_stat[0]) begin
          out_data_d  = net_result;
          job_count_d = job_count_q + 16'd1;
          state_d     = ST_OUTPUT;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT_LIM - 1)) begin
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset forces start low without a clock.
  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = (state_q == ST_OUTPUT);
  assign net_ctrl    = {7'b0, state_q == ST_START};
  assign net_data    = net_data_q;
  assign out_data    = out_data_q;
  assign job_count   = job_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_network_sequencer.sv
// tb/tb_network_sequencer.sv - scoreboard bench for network_sequencer with a controller model
module tb_network_sequencer;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0][31:0] in_data;
  logic [7:0]       net_ctrl;
  logic [7:0]       net_stat;
  logic [1:0][31:0] net_data;
  logic [0:0][31:0] net_result;
  logic             out_valid;
  logic             out_ready;
  logic [0:0][31:0] out_data;
  logic             busy;
  logic             timeout_err;
  logic [15:0]      job_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  // controller model state
  int fin_delay = -1;
  int mcnt      = 0;
  bit armed     = 0;
  bit stray     = 0;
  bit prev_start = 0;
  int starts    = 0;

  network_sequencer #(
    .INPUT_SIZE(2), .OUTPUT_SIZE(1), .BITSTREAM_LENGTH(256), .TIMEOUT_CYCLES(300)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .net_ctrl(net_ctrl), .net_stat(net_stat), .net_data(net_data), .net_result(net_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .timeout_err(timeout_err), .job_count(job_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Controller model: counts cycles from the start pulse and raises finish once.
  always @(negedge clk) begin
    if (!n_rst) begin
      armed = 0;
    end else if (net_ctrl[0]) begin
      check("start_single_cycle", {63'b0, prev_start}, 64'd0);
      starts++;
      armed = 1;
      mcnt  = 0;
    end else if (armed) begin
      mcnt++;
    end
    prev_start = net_ctrl[0];
    if (armed && mcnt == fin_delay) begin
      net_stat = 8'b0100_0001;
      armed    = 0;
    end else begin
      net_stat = {armed, 6'b0, stray};
    end
  end

  // Scoreboard: every accepted result must match the oldest expected one.
  always @(negedge clk) begin
    if (n_rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", {63'b0, out_valid}, 64'd0);
      else check("sb_out_data", {32'b0, out_data[0]}, {32'b0, exp_q.pop_front()});
    end
  end

  // Drive one job and stop at the negedge of the start-pulse cycle.
  task automatic send(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] res,
                      input int fin, input bit expect_out);
    fin_delay     = fin;
    net_result[0] = res;
    in_data[0]    = a0;
    in_data[1]    = a1;
    in_valid      = 1'b1;
    smp();
    check("accept_ready", {63'b0, in_ready}, 64'd1);
    if (expect_out) exp_q.push_back(res);
    step();
    in_valid = 1'b0;
    smp();
    check("start_pulse", {56'b0, net_ctrl}, 64'd1);
    check("net_data_latched", net_data, {a1, a0});
    check("in_ready_start", {63'b0, in_ready}, 64'd0);
  endtask

  task automatic wait_out(input int lim, output int n);
    n = 0;
    while (!out_valid && n < lim) begin
      smp();
      n++;
    end
    check("out_valid_seen", {63'b0, out_valid}, 64'd1);
  endtask

  task automatic wait_err(input int lim, output int n);
    n = 0;
    while (!timeout_err && n < lim) begin
      smp();
      n++;
    end
    check("timeout_err_seen", {63'b0, timeout_err}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    n_rst = 1'b0; in_valid = 1'b0; in_data = '0; net_result = '0; out_ready = 1'b0;
    net_stat = '0;
    repeat (3) step();
    smp();
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);
    check("rst_net_ctrl", {56'b0, net_ctrl}, 64'd0);
    check("rst_net_data", net_data, 64'd0);
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_out_data", {32'b0, out_data}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_timeout_err", {63'b0, timeout_err}, 64'd0);
    check("rst_job_count", {48'b0, job_count}, 64'd0);
    step();
    n_rst = 1'b1;
    step();

    // nominal job with downstream stalled
    send(32'd100, -32'sd50, 32'd37, 258, 1'b1);
    wait_out(400, n);
    check("nom_latency", n, 64'd259);
    check("nom_out_data", {32'b0, out_data}, 64'd37);
    check("nom_job_count", {48'b0, job_count}, 64'd1);
    check("nom_starts", starts, 64'd1);

    // backpressure: result held, new input ignored
    step();
    net_result[0] = 32'd99;
    in_valid      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      smp();
      check("bp_out_valid", {63'b0, out_valid}, 64'd1);
      check("bp_out_data", {32'b0, out_data}, 64'd37);
      check("bp_in_ready", {63'b0, in_ready}, 64'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    smp();
    step();
    smp();
    check("bp_idle_in_ready", {63'b0, in_ready}, 64'd1);
    check("bp_idle_out_valid", {63'b0, out_valid}, 64'd0);
    repeat (3) step();
    smp();
    check("bp_no_queued_job", starts, 64'd1);
    check("bp_busy", {63'b0, busy}, 64'd0);

    // stray finish in IDLE
    step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    smp();
    check("stray_busy", {63'b0, busy}, 64'd0);
    check("stray_out_valid", {63'b0, out_valid}, 64'd0);
    check("stray_job_count", {48'b0, job_count}, 64'd1);
    step();

    // finish coincides with timeout limit
    send(32'd5, 32'd6, 32'd77, 300, 1'b1);
    wait_out(400, n);
    check("tie_latency", n, 64'd301);
    check("tie_timeout_err", {63'b0, timeout_err}, 64'd0);
    check("tie_job_count", {48'b0, job_count}, 64'd2);
    step();
    smp();
    check("tie_idle", {63'b0, busy}, 64'd0);
    step();

    // timeout: controller never finishes
    send(32'd7, 32'd8, 32'd0, -1, 1'b0);
    wait_err(400, n);
    check("to_latency", n, 64'd301);
    check("to_busy", {63'b0, busy}, 64'd0);
    check("to_in_ready", {63'b0, in_ready}, 64'd1);
    check("to_out_data", {32'b0, out_data}, 64'd77);
    check("to_job_count", {48'b0, job_count}, 64'd2);
    step();

    // second nominal job after the error; error stays set
    send(32'd9, 32'd10, 32'd55, 258, 1'b1);
    wait_out(400, n);
    check("nom2_latency", n, 64'd259);
    check("nom2_job_count", {48'b0, job_count}, 64'd3);
    check("nom2_timeout_err", {63'b0, timeout_err}, 64'd1);
    step();
    step();

    // reset 100 cycles into WAIT
    send(32'd11, 32'd12, 32'd0, -1, 1'b0);
    repeat (100) step();
    #2 n_rst = 1'b0;
    #1;
    check("mrst_busy", {63'b0, busy}, 64'd0);
    check("mrst_in_ready", {63'b0, in_ready}, 64'd1);
    check("mrst_net_ctrl", {56'b0, net_ctrl}, 64'd0);
    check("mrst_out_valid", {63'b0, out_valid}, 64'd0);
    check("mrst_job_count", {48'b0, job_count}, 64'd0);
    check("mrst_timeout_err", {63'b0, timeout_err}, 64'd0);
    check("mrst_net_data", net_data, 64'd0);
    check("mrst_out_data", {32'b0, out_data}, 64'd0);
    step();
    n_rst = 1'b1;
    step();

    // reset while the start pulse is high forces it low without a clock edge
    in_data[0] = 32'd13;
    in_data[1] = 32'd14;
    in_valid   = 1'b1;
    step();
    in_valid = 1'b0;
    check("arst_pulse_high", {56'b0, net_ctrl}, 64'd1);
    #1 n_rst = 1'b0;
    #1;
    check("arst_pulse_low", {56'b0, net_ctrl}, 64'd0);
    step();
    n_rst = 1'b1;
    repeat (5) step();
    smp();
    check("arst_idle", {63'b0, busy}, 64'd0);
    check("arst_out_valid", {63'b0, out_valid}, 64'd0);
    check("sb_empty", exp_q.size(), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
